mio_bus_responder: RTL and testbench

- Memory/IO responder for the multi-cycle CPU datapath: answers CPU read/write requests on the shared address/data bus and drives `MIO_ready` and `data2CPU` back to the CPU.
- Contains a word-addressed data RAM, an LED output register, a switch input port and a free-running cycle counter.
- Inserts a programmable number of wait states per access, so the CPU's ready-gated PC and state sequencing can be exercised.

---
 rtl/mio_bus_responder.sv | 141 ++++++++++++++
 tb/tb_mio_bus_responder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mio_bus_responder.sv
// Purpose: memory/IO responder for the multi-cycle CPU bus (data RAM, LED register, switch port, cycle counter).
// Latency: WAIT_CYC+1 cycles with MIO_ready low per access, then one DONE cycle with MIO_ready high.
// Backpressure: MIO_ready low stalls the CPU; dropping the request mid-wait aborts with no commit.
module mio_bus_responder #(
   parameter int ADDR_W   = 10,
   parameter int WAIT_CYC = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_r,
   input  logic        mem_w,
   input  logic [31:0] M_addr,
   input  logic [31:0] data_out,
   output logic [31:0] data2CPU,
   output logic        MIO_ready,
   input  logic [15:0] sw_in,
   output logic [7:0]  led_out
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

   logic [1:0]        state;
   logic [3:0]        wait_cnt;
   logic [31:0]       cyc_cnt;
   logic [31:0]       ram [0:(1<<ADDR_W)-1];

   logic              req;
   logic              is_io;
   logic [1:0]        io_off;
   logic [ADDR_W-1:0] word_idx;
   logic              commit;
   logic [31:0]       rd_dat;
   logic              unused_addr_bits;

   assign req      = mem_r | mem_w;
   assign is_io    = (M_addr[31:28] == 4'hF);
   assign io_off   = M_addr[3:2];
   assign word_idx = M_addr[ADDR_W+1:2];

   // Byte-lane bits and RAM alias bits never take part in decode.
   assign unused_addr_bits = ^{M_addr[27:4], M_addr[1:0]};

   assign MIO_ready = (state == ST_DONE) | ((state == ST_IDLE) & ~req);

   // Commit happens on the edge that moves the FSM into DONE.
   always_comb begin
      commit = 1'b0;
      if (req) begin
         case (state)
            ST_IDLE: commit = (WAIT_CYC == 0);
            ST_WAIT: commit = (wait_cnt == 4'd1);
            default: commit = 1'b0;
         endcase
      end
   end

   // Read data mux: IO registers or RAM word (asynchronous read, captured on commit).
   always_comb begin
      rd_dat = 32'h0;
      if (is_io) begin
         case (io_off)
            2'd0:    rd_dat = {24'h0, led_out};
            2'd1:    rd_dat = {16'h0, sw_in};
            2'd2:    rd_dat = cyc_cnt;
            default: rd_dat = 32'h0;
         endcase
      end else begin
         rd_dat = ram[word_idx];
      end
   end

   // Access sequencing: IDLE -> WAIT (wait states) -> DONE -> IDLE; dropped request aborts.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         wait_cnt <= 4'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req) begin
                  if (WAIT_CYC == 0) begin
                     state <= ST_DONE;
                  end else begin
                     state    <= ST_WAIT;
                     wait_cnt <= WAIT_INIT;
                  end
               end
            end
            ST_WAIT: begin
               if (!req) begin
                  state    <= ST_IDLE;
                  wait_cnt <= 4'd0;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
                  if (wait_cnt == 4'd1) begin
                     state <= ST_DONE;
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // IO registers, read capture and the free-running counter; a counter write beats the increment.
   always_ff @(posedge clk) begin
      if (reset) begin
         data2CPU <= 32'h0;
         led_out  <= 8'h0;
         cyc_cnt  <= 32'h0;
      end else begin
         cyc_cnt <= cyc_cnt + 32'd1;
         if (commit) begin
            if (mem_w) begin
               if (is_io) begin
                  case (io_off)
                     2'd0:    led_out <= data_out[7:0];
                     2'd2:    cyc_cnt <= data_out;
                     default: ;
                  endcase
               end
            end else begin
               data2CPU <= rd_dat;
            end
         end
      end
   end

   // RAM write port; contents survive reset, but a commit coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (!reset && commit && mem_w && !is_io) begin
         ram[word_idx] <= data_out;
      end
   end

endmodule

// File: tb/tb_mio_bus_responder.sv
// Purpose: directed self-checking bench for mio_bus_responder with WAIT_CYC=2 and WAIT_CYC=0 instances.
// Latency: checks MIO_ready low-cycle counts and commit timing against hand-computed values.
// Backpressure: exercises request abort, reset during a wait and back-to-back held requests.
module tb_mio_bus_responder;

   logic        clk;
   logic        reset;
   logic [15:0] sw_in;

   logic        mem_r, mem_w;
   logic [31:0] M_addr, data_out, data2CPU;
   logic        ready;
   logic [7:0]  led_out;

   logic        z_mem_r, z_mem_w;
   logic [31:0] z_addr, z_wdat, z_d2c;
   logic        z_ready;
   logic [7:0]  z_led;

   int checks   = 0;
   int failures = 0;

   mio_bus_responder #(.ADDR_W(10), .WAIT_CYC(2)) dut (
      .clk(clk), .reset(reset), .mem_r(mem_r), .mem_w(mem_w),
      .M_addr(M_addr), .data_out(data_out), .data2CPU(data2CPU),
      .MIO_ready(ready), .sw_in(sw_in), .led_out(led_out)
   );

   mio_bus_responder #(.ADDR_W(10), .WAIT_CYC(0)) dut_z (
      .clk(clk), .reset(reset), .mem_r(z_mem_r), .mem_w(z_mem_w),
      .M_addr(z_addr), .data_out(z_wdat), .data2CPU(z_d2c),
      .MIO_ready(z_ready), .sw_in(sw_in), .led_out(z_led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One complete access: drive after a rising edge, count low-ready cycles, drop after DONE.
   task automatic access(input bit z, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d, output int low);
      @(posedge clk); #1;
      if (z) begin
         z_mem_r = r; z_mem_w = w; z_addr = a; z_wdat = d;
      end else begin
         mem_r = r; mem_w = w; M_addr = a; data_out = d;
      end
      low = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ((z ? z_ready : ready) === 1'b1) break;
         low++;
      end
      @(posedge clk); #1;
      mem_r = 1'b0; mem_w = 1'b0; z_mem_r = 1'b0; z_mem_w = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      mem_r = 0; mem_w = 0; M_addr = 0; data_out = 0;
      z_mem_r = 0; z_mem_w = 0; z_addr = 0; z_wdat = 0;
      sw_in = 16'h1234;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
      checks++; if (data2CPU !== 32'h0) begin failures++; $display("FAIL reset_d2c got=%h exp=0", data2CPU); end
      checks++; if (led_out !== 8'h0) begin failures++; $display("FAIL reset_led got=%h exp=0", led_out); end
      checks++; if (z_ready !== 1'b1) begin failures++; $display("FAIL reset_z_ready got=%b exp=1", z_ready); end
   endtask

   task automatic test_ram_rw;
      int low;
      access(0, 0, 1, 32'h10, 32'hDEADBEEF, low);
      checks++; if (low !== 3) begin failures++; $display("FAIL ram_wr_low got=%0d exp=3", low); end
      access(0, 1, 0, 32'h10, 32'h0, low);
      checks++; if (low !== 3) begin failures++; $display("FAIL ram_rd_low got=%0d exp=3", low); end
      checks++; if (data2CPU !== 32'hDEADBEEF) begin failures++; $display("FAIL ram_rd_dat got=%h exp=deadbeef", data2CPU); end
   endtask

   task automatic test_write_priority;
      int low;
      access(0, 1, 1, 32'h20, 32'h55, low);
      checks++; if (data2CPU !== 32'hDEADBEEF) begin failures++; $display("FAIL both_d2c_hold got=%h exp=deadbeef", data2CPU); end
      access(0, 1, 0, 32'h20, 32'h0, low);
      checks++; if (data2CPU !== 32'h55) begin failures++; $display("FAIL both_ram_wr got=%h exp=55", data2CPU); end
   endtask

   task automatic test_io;
      int low;
      access(0, 0, 1, 32'hF000_0000, 32'h0000_01A5, low);
      checks++; if (led_out !== 8'hA5) begin failures++; $display("FAIL led_wr got=%h exp=a5", led_out); end
      access(0, 1, 0, 32'hF000_0000, 32'h0, low);
      checks++; if (data2CPU !== 32'hA5) begin failures++; $display("FAIL led_rd got=%h exp=a5", data2CPU); end
      access(0, 1, 0, 32'hF000_0004, 32'h0, low);
      checks++; if (data2CPU !== 32'h1234) begin failures++; $display("FAIL sw_rd got=%h exp=1234", data2CPU); end
      access(0, 1, 0, 32'hF123_0000, 32'h0, low);
      checks++; if (data2CPU !== 32'hA5) begin failures++; $display("FAIL io_alias_rd got=%h exp=a5", data2CPU); end
   endtask

   task automatic test_abort;
      int low;
      access(0, 0, 1, 32'h40, 32'h77, low);
      @(posedge clk); #1;
      mem_w = 1'b1; M_addr = 32'h40; data_out = 32'h11;
      @(posedge clk);
      @(negedge clk);
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL abort_wait_ready got=%b exp=0", ready); end
      @(posedge clk); #1 mem_w = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL abort_idle_ready got=%b exp=1", ready); end
      access(0, 1, 0, 32'h40, 32'h0, low);
      checks++; if (low !== 3) begin failures++; $display("FAIL abort_rd_low got=%0d exp=3", low); end
      checks++; if (data2CPU !== 32'h77) begin failures++; $display("FAIL abort_rd_dat got=%h exp=77", data2CPU); end
   endtask

   task automatic test_counter;
      int low;
      // Loaded FFFFFFFE; +1 leaving DONE, wraps to 0 on the idle edge, two more edges before commit.
      access(0, 0, 1, 32'hF000_0008, 32'hFFFF_FFFE, low);
      access(0, 1, 0, 32'hF000_0008, 32'h0, low);
      checks++; if (data2CPU !== 32'h2) begin failures++; $display("FAIL cnt_wrap got=%h exp=2", data2CPU); end
   endtask

   task automatic test_reset_mid_wait;
      @(posedge clk); #1;
      mem_w = 1'b1; M_addr = 32'hF000_0000; data_out = 32'h3C;
      @(posedge clk);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0; mem_w = 1'b0;
      @(negedge clk);
      checks++; if (led_out !== 8'h0) begin failures++; $display("FAIL rst_mid_led got=%h exp=0", led_out); end
      checks++; if (data2CPU !== 32'h0) begin failures++; $display("FAIL rst_mid_d2c got=%h exp=0", data2CPU); end
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", ready); end
   endtask

   task automatic test_zero_wait;
      int low;
      access(1, 0, 1, 32'h100, 32'hCAFE_F00D, low);
      checks++; if (low !== 1) begin failures++; $display("FAIL z_wr_low got=%0d exp=1", low); end
      access(1, 1, 0, 32'h100, 32'h0, low);
      checks++; if (low !== 1) begin failures++; $display("FAIL z_rd_low got=%0d exp=1", low); end
      checks++; if (z_d2c !== 32'hCAFE_F00D) begin failures++; $display("FAIL z_rd_dat got=%h exp=cafef00d", z_d2c); end
      access(1, 1, 0, 32'h1100, 32'h0, low);
      checks++; if (z_d2c !== 32'hCAFE_F00D) begin failures++; $display("FAIL z_ram_alias got=%h exp=cafef00d", z_d2c); end
      access(1, 0, 1, 32'hF000_000C, 32'h1234_5678, low);
      access(1, 1, 0, 32'hF000_000C, 32'h0, low);
      checks++; if (z_d2c !== 32'h0) begin failures++; $display("FAIL z_unmapped got=%h exp=0", z_d2c); end
   endtask

   task automatic test_back_to_back;
      logic [3:0] seen;
      @(posedge clk); #1;
      z_mem_r = 1'b1; z_addr = 32'h100;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         seen[i] = z_ready;
      end
      @(posedge clk); #1 z_mem_r = 1'b0;
      checks++; if (seen !== 4'b1010) begin failures++; $display("FAIL b2b_ready got=%b exp=1010", seen); end
      @(negedge clk);
      checks++; if (z_ready !== 1'b1) begin failures++; $display("FAIL b2b_idle got=%b exp=1", z_ready); end
   endtask

   initial begin
      test_reset;
      test_ram_rw;
      test_write_priority;
      test_io;
      test_abort;
      test_counter;
      test_reset_mid_wait;
      test_zero_wait;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
